// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and constants for the UART receive monitor.
// The FSM encoding always contains PARITY, including builds without parity support.
package uart_rx_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Smallest usable HCLK-per-bit divider; smaller requests are raised to this.
  localparam int MIN_DIV = 4;

  // Number of flops in the rx metastability synchroniser.
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/uart_rx_monitor_fifo.sv
// Synchronous show-ahead FIFO for received characters.
// rdata shows the head entry, and reads as zero while the FIFO is empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_monitor_fifo
  import uart_rx_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_en, rd_en;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Decide which accesses take effect and advance pointers/occupancy (pointers wrap naturally).
  always_comb begin
    wr_en    = push & (~full | pop);
    rd_en    = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);
  end

  // Pointer and occupancy state; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Character storage; contents are meaningless until written, so it is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: rx synchroniser, oversampling receive FSM, sticky
// error flags, and a show-ahead character FIFO behind a valid/ready port.
// Optional parity checking is compiled in with `define UART_RX_MONITOR_PARITY_EN.
module uart_rx_monitor
  import uart_rx_monitor_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
`ifdef UART_RX_MONITOR_PARITY_EN
  parameter int DIV_W      = 16,
  parameter bit PARITY_ODD = 1'b0
`else
  parameter int DIV_W      = 16
`endif
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              baud_div,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          clr_err
);

  localparam int BCW = $clog2(DATA_BITS + 1);

  // Raise dividers below the minimum to the minimum.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_W'(MIN_DIV)) return DIV_W'(MIN_DIV);
    return d;
  endfunction

`ifdef UART_RX_MONITOR_PARITY_EN
  // True when the received parity bit disagrees with the configured parity sense.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic pbit);
    return (^d ^ PARITY_ODD) != pbit;
  endfunction
`endif

  // ---------------- synchroniser and edge detect ----------------
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  rx_prev_q;
  logic                  rx_s;
  logic                  fall;

  assign rx_s = sync_q[SYNC_DEPTH-1];
  assign fall = rx_prev_q & ~rx_s;

  // Shift the raw line into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], rx};
  end

  // Synchroniser and previous-sample flops preset to idle-high so reset never fakes an edge.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_s;
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_e          state_q;
  logic [DIV_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BCW-1:0]     bit_cnt_q;
  logic               stop_cnt_q;
  logic               stop_bad_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  logic [DIV_W-1:0]   half_m1, full_m1;
  logic               tick_half, tick_full;
  logic               last_data, last_stop;
  logic               load_div, shift_en;
  logic               push_chr, frame_ev, parity_ev, overrun_ev;
  logic               fifo_full, fifo_empty, pop;

  // Sample-point decode and per-frame events derived from the current FSM state.
  always_comb begin
    half_m1   = (div_q >> 1) - DIV_W'(1);
    full_m1   = div_q - DIV_W'(1);
    tick_half = (cnt_q == half_m1);
    tick_full = (cnt_q == full_m1);
    last_data = (bit_cnt_q == BCW'(DATA_BITS - 1));
    last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
    load_div  = (state_q == ST_IDLE) && fall;
    div_d     = load_div ? clamp_div(baud_div) : div_q;
    shift_en  = (state_q == ST_DATA) && tick_full;
    shift_d   = shift_en ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
    push_chr  = (state_q == ST_STOP) && tick_full && last_stop && !stop_bad_q && rx_s;
    frame_ev  = (state_q == ST_STOP) && tick_full && last_stop && (stop_bad_q || !rx_s);
`ifdef UART_RX_MONITOR_PARITY_EN
    parity_ev = (state_q == ST_PARITY) && tick_full && parity_bad(shift_q, rx_s);
`else
    parity_ev = 1'b0;
`endif
  end

  // Divider snapshot and data shifter carry no control meaning, so they are not reset.
  always_ff @(posedge HCLK) begin
    div_q   <= div_d;
    shift_q <= shift_d;
  end

  // Frame sequencing: start-bit qualification, data, optional parity, stop bits.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (fall) state_q <= ST_START;
        end
        ST_START: begin
          if (tick_half) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_full) begin
            cnt_q <= '0;
            if (last_data) begin
              stop_cnt_q <= 1'b0;
              stop_bad_q <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
              state_q    <= ST_PARITY;
`else
              state_q    <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
`ifdef UART_RX_MONITOR_PARITY_EN
        ST_PARITY: begin
          if (tick_full) begin
            cnt_q   <= '0;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_full) begin
            cnt_q <= '0;
            if (last_stop) begin
              state_q <= ST_IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
              stop_bad_q <= stop_bad_q | ~rx_s;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

  // ---------------- sticky error flags ----------------
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;
  logic parity_err_q, parity_err_d;

  // A same-cycle clear and new error leave the flag set.
  always_comb begin
    overrun_ev   = push_chr && fifo_full && !pop;
    frame_err_d  = (frame_err_q  & ~clr_err) | frame_ev;
    overrun_d    = (overrun_q    & ~clr_err) | overrun_ev;
    parity_err_d = (parity_err_q & ~clr_err) | parity_ev;
  end

  // Sticky flag storage.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

  // ---------------- character FIFO ----------------
  assign pop      = rx_valid & rx_ready;
  assign rx_valid = ~fifo_empty;

  uart_rx_monitor_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push_chr),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: 8N1, FIFO_DEPTH=4, baud_div=16 unless noted.
module tb_uart_rx_monitor;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       rx;
  logic [15:0] baud_div;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] fifo_level;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       clr_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  logic [7:0] last_pop = 8'h00;

`ifdef UART_RX_MONITOR_PARITY_EN
  // 0: correct even parity, 1: force parity bit 1, 2: force parity bit 0
  int par_mode = 0;
`endif

  always #5 HCLK = ~HCLK;

  uart_rx_monitor #(
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .rx         (rx),
    .baud_div   (baud_div),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_level (fifo_level),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .clr_err    (clr_err)
  );

  // Record every accepted character (handshake seen on the falling edge before the pop edge).
  always @(negedge HCLK) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      pop_cnt  = pop_cnt + 1;
      last_pop = rx_data;
    end
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int cyc);
    rx = b;
    cycles(cyc);
  endtask

  // Full frame: start, 8 data bits LSB first, optional parity, one stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int cyc);
    logic p;
    drive_bit(1'b0, cyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cyc);
`ifdef UART_RX_MONITOR_PARITY_EN
    p = ^d;
    if (par_mode == 1) p = 1'b1;
    if (par_mode == 2) p = 1'b0;
    drive_bit(p, cyc);
`else
    p = 1'b0;
`endif
    drive_bit(stop_v, cyc);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    cycles(1);
  endtask

  initial begin
    int pc;
    HRESET   = 1'b1;
    rx       = 1'b1;
    baud_div = 16'd16;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    cycles(4);

    // Reset state
    check("rst_valid",  32'(rx_valid),   32'd0);
    check("rst_data",   32'(rx_data),    32'd0);
    check("rst_level",  32'(fifo_level), 32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_ferr",   32'(frame_err),  32'd0);
    check("rst_ovr",    32'(overrun),    32'd0);
    check("rst_perr",   32'(parity_err), 32'd0);
    HRESET = 1'b0;
    cycles(5);

    // Basic receive of 0x41
    rx_ready = 1'b1;
    pc = pop_cnt;
    send_frame(8'h41, 1'b1, 16);
    cycles(4);
    check("basic_pops",  32'(pop_cnt - pc), 32'd1);
    check("basic_data",  32'(last_pop),     32'h41);
    check("basic_valid", 32'(rx_valid),     32'd0);
    check("basic_busy",  32'(busy),         32'd0);
    check("basic_ferr",  32'(frame_err),    32'd0);
    check("basic_ovr",   32'(overrun),      32'd0);
    check("basic_perr",  32'(parity_err),   32'd0);

    // Glitch rejection: short low pulse
    pc = pop_cnt;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    check("glitch_level", 32'(fifo_level),   32'd0);
    check("glitch_pops",  32'(pop_cnt - pc), 32'd0);
    check("glitch_busy",  32'(busy),         32'd0);

    // Framing error
    pc = pop_cnt;
    send_frame(8'h55, 1'b0, 16);
    cycles(20);
    check("ferr_flag",  32'(frame_err),    32'd1);
    check("ferr_level", 32'(fifo_level),   32'd0);
    check("ferr_pops",  32'(pop_cnt - pc), 32'd0);
    pulse_clr();
    check("ferr_clr",   32'(frame_err),    32'd0);

    // Overrun: five characters into a four-entry FIFO
    rx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 16);
    cycles(2);
    check("ovr_level4", 32'(fifo_level), 32'd4);
    check("ovr_before", 32'(overrun),    32'd0);
    send_frame(8'h05, 1'b1, 16);
    cycles(2);
    check("ovr_level",  32'(fifo_level), 32'd4);
    check("ovr_flag",   32'(overrun),    32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("ovr_pop_valid", 32'(rx_valid), 32'd1);
      check("ovr_pop_data",  32'(rx_data),  32'(k));
      rx_ready = 1'b1;
      cycles(1);
      rx_ready = 1'b0;
    end
    check("ovr_empty", 32'(rx_valid),   32'd0);
    check("ovr_lvl0",  32'(fifo_level), 32'd0);
    pulse_clr();
    check("ovr_clr",   32'(overrun),    32'd0);

    // Divider clamp: baud_div=2 acts as 4
    baud_div = 16'd2;
    cycles(3);
    send_frame(8'h7E, 1'b1, 4);
    cycles(3);
    check("clamp_valid", 32'(rx_valid),   32'd1);
    check("clamp_data",  32'(rx_data),    32'h7E);
    check("clamp_ferr",  32'(frame_err),  32'd0);

    // Reset in the middle of a frame
    baud_div = 16'd16;
    cycles(2);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    check("mid_busy", 32'(busy), 32'd1);
    HRESET = 1'b1;
    rx     = 1'b1;
    cycles(3);
    HRESET = 1'b0;
    cycles(1);
    check("rstmid_busy",  32'(busy),       32'd0);
    check("rstmid_level", 32'(fifo_level), 32'd0);
    check("rstmid_valid", 32'(rx_valid),   32'd0);
    cycles(20);
    send_frame(8'h33, 1'b1, 16);
    cycles(3);
    check("after_valid", 32'(rx_valid),   32'd1);
    check("after_data",  32'(rx_data),    32'h33);
    check("after_level", 32'(fifo_level), 32'd1);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    check("after_pop", 32'(rx_valid), 32'd0);

`ifdef UART_RX_MONITOR_PARITY_EN
    // Parity: 0x03 with parity bit 1 is an even-parity error but is still pushed
    par_mode = 1;
    send_frame(8'h03, 1'b1, 16);
    cycles(3);
    check("par_valid", 32'(rx_valid),   32'd1);
    check("par_data",  32'(rx_data),    32'h03);
    check("par_err",   32'(parity_err), 32'd1);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    pulse_clr();
    check("par_clr",   32'(parity_err), 32'd0);
    par_mode = 2;
    send_frame(8'h03, 1'b1, 16);
    cycles(3);
    check("par_ok_data", 32'(rx_data),    32'h03);
    check("par_ok_err",  32'(parity_err), 32'd0);
    par_mode = 0;
`else
    check("noparity_tie", 32'(parity_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Clocked, parametrised UART receive monitor for the SoC bench and for on-chip debug capture. Replaces the fixed-delay, 8N1-only serial terminal model.
- Oversamples a serial line at a runtime-programmable baud divider and supports 5–8 data bits and 1–2 stop bits.
- Buffers received characters in a FIFO behind a valid/ready stream, with sticky frame and overrun error flags.

Parameters:
- DATA_BITS, 8, character width; legal range 5..8.
- STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.
- FIFO_DEPTH, 8, received-character buffer entries; must be a power of two and at least 2.
- DIV_W, 16, width of the baud divider input.

Ports:
- HCLK  in  1  sole clock.
- HRESET  in  1  synchronous, active-high reset.
- rx  in  1  serial line, asynchronous; idles high.
- baud_div  in  DIV_W  HCLK cycles per bit; values below 4 are treated as 4.
- rx_data  out  DATA_BITS  head-of-FIFO character (show-ahead).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pop; a pop occurs when rx_valid & rx_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FSM not in IDLE.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a character arrived while the FIFO was full.
- parity_err  out  1  sticky; see Optional Feature.
- clr_err  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset: every output is 0, except rx_data, which is 0 because the FIFO is empty. The synchroniser flops are preset to 1, the FSM goes to IDLE, the FIFO empties, and the bit counters clear. A reset during a frame aborts it and discards any partial character.
- rx passes through a 2-FF synchroniser; every reference to rx below means the synchronised value.
- Let D = max(baud_div, 4). baud_div is sampled into an internal register on each IDLE->START transition, so changing it mid-frame has no effect until the next frame.
- FSM states:
  - IDLE: move to START on a 1->0 edge of rx.
  - START: count D/2 (floored) cycles, then sample. If rx is 1, treat it as a false start and return to IDLE with nothing pushed. If rx is 0, go to DATA.
  - DATA: sample every D cycles. DATA_BITS samples are shifted in LSB first, then go to PARITY if enabled, otherwise to STOP.
  - PARITY: one sample D cycles later, then go to STOP.
  - STOP: sample STOP_BITS times, D cycles apart. If any stop sample is 0, set frame_err, discard the character and return to IDLE. Otherwise push the character and return to IDLE.
- After the final stop sample, IDLE watches immediately for a new falling edge. Back-to-back frames are supported with no idle gap.
- Push timing: the character is written on the cycle of the final stop sample. rx_valid rises on the next cycle when the FIFO was empty.
- FIFO boundary cases:
  - Push while full with no pop: the new character is dropped, overrun is set, and contents are unchanged.
  - Push and pop together while full: both occur and the level is unchanged.
  - Push and pop together while empty: only the push takes effect.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - Remain set until clr_err or HRESET.
  - If clr_err and a new error event occur in the same cycle, the flag ends set.
- A character whose stop bit fails is never pushed. A character with a parity error is still pushed.

Optional Feature:
- Macro: UART_RX_MONITOR_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity) and the PARITY state.
  - A mismatch sets parity_err and the character is still pushed.
- Undefined:
  - No PARITY state and no parity logic.
  - parity_err is tied to 0 and the port remains present.

Decomposition:
- Package uart_rx_monitor_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - the minimum-divider constant (4);
  - the synchroniser depth constant (2).
- One sub-module, uart_rx_monitor_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH and ports push, pop, full, empty and level. The FSM, synchroniser and sticky flags stay in the top module.

Test Plan (all with baud_div=16, 8N1, FIFO_DEPTH=4):
- Basic receive: drive 0x41 with 16 cycles per bit and rx_ready=1 -> rx_valid pulses with rx_data=0x41; no error flags; busy falls after the stop sample.
- Glitch rejection: drive rx low for 5 cycles, then high -> START aborts to IDLE; no push; fifo_level stays 0.
- Framing error: send 0x55 with the stop bit driven 0 -> frame_err=1 and FIFO empty. Pulse clr_err -> frame_err=0.
- Overrun: hold rx_ready=0 and send 0x01..0x05 -> fifo_level=4 and overrun=1. Then pop 4 characters -> 0x01,0x02,0x03,0x04 in order, after which rx_valid=0.
- Divider clamp and reset: set baud_div=2 and send 0x7E at 4 cycles per bit -> received correctly. Assert HRESET during the DATA state -> busy=0 and fifo_level=0; the next full frame 0x33 is received correctly.
- Parity (macro defined, PARITY_ODD=0): send 0x03 with parity bit 1 -> rx_data=0x03 is pushed and parity_err=1. Send the same character with parity bit 0 after clr_err -> parity_err stays 0.
